boss_missile_scheduler: RTL and testbench

Schedules boss fire for the level-3 boss fight: owns a pool of boss projectile slots, paces shots in frame-counted bursts separated by cooldowns, and allocates each shot to the lowest free slot. Sits between `boss` (position source) and the boss projectile instances, which report in-flight status and consume one-cycle fire strobes. Counterpart to the player-side missile selection, but self-timed rather than button-driven.

---
 rtl/boss_missile_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_boss_missile_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boss_missile_scheduler.sv
// Boss fire scheduler: frame-paced bursts with cooldowns, each shot launched on the lowest free slot.
// Define BOSS_AIM_EN to add the AIM state (fire_dir tracks the player); otherwise fire_dir stays 00.
module boss_missile_scheduler #(
    parameter int unsigned NUM_SLOTS        = 3,
    parameter int unsigned COOLDOWN_FRAMES  = 30,
    parameter int unsigned BURST_LEN        = 3,
    parameter int unsigned BURST_GAP_FRAMES = 6,
    parameter int unsigned AIM_DEADZONE     = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic                 enable,
    input  logic [9:0]           boss_x_pos,
    input  logic [9:0]           player_x_pos,
    input  logic [NUM_SLOTS-1:0] slot_active,
    output logic [NUM_SLOTS-1:0] fire,
    output logic [9:0]           fire_x_pos,
    output logic [1:0]           fire_dir,
    output logic                 busy,
    output logic [15:0]          shots_fired
);

    localparam int unsigned CNT_MAX = (COOLDOWN_FRAMES > BURST_GAP_FRAMES) ? COOLDOWN_FRAMES
                                                                           : BURST_GAP_FRAMES;
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam int unsigned BC_W    = (BURST_LEN < 2) ? 1 : $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COOLDOWN,
        S_AIM,
        S_BURST,
        S_GAP
    } state_t;

    state_t               state;
    logic                 frame_q;
    logic                 tick;
    logic [CNT_W-1:0]     cnt;
    logic [BC_W-1:0]      burst_cnt;
    logic [BC_W:0]        burst_next;
    logic                 burst_last;
    logic [NUM_SLOTS-1:0] reserved;
    logic [NUM_SLOTS-1:0] reserved_kept;
    logic [NUM_SLOTS-1:0] free;
    logic [NUM_SLOTS-1:0] pick;

    assign tick = frame_clk & ~frame_q;

    always_comb begin
        free          = ~slot_active & ~reserved;
        // two's-complement trick isolates the lowest set bit
        pick          = free & (~free + NUM_SLOTS'(1));
        reserved_kept = tick ? '0 : (reserved & ~slot_active);
        burst_next    = {1'b0, burst_cnt} + (BC_W + 1)'(1);
        burst_last    = (burst_next == (BC_W + 1)'(BURST_LEN));
    end

`ifdef BOSS_AIM_EN
    logic [1:0]         dir_r;
    logic [1:0]         fire_dir_r;
    logic [1:0]         aim_dir;
    logic signed [11:0] px;
    logic signed [11:0] bound_lo;
    logic signed [11:0] bound_hi;

    // 12-bit signed keeps boss +/- deadzone from wrapping at the screen edges
    always_comb begin
        px       = $signed({2'b00, player_x_pos});
        bound_lo = $signed({2'b00, boss_x_pos}) - $signed(12'(AIM_DEADZONE));
        bound_hi = $signed({2'b00, boss_x_pos}) + $signed(12'(AIM_DEADZONE));
        if (px < bound_lo) begin
            aim_dir = 2'b01;
        end else if (px > bound_hi) begin
            aim_dir = 2'b10;
        end else begin
            aim_dir = 2'b00;
        end
    end

    assign fire_dir = fire_dir_r;
`else
    logic unused_player;
    assign unused_player = ^player_x_pos;
    assign fire_dir      = 2'b00;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            frame_q     <= 1'b0;
            cnt         <= '0;
            burst_cnt   <= '0;
            reserved    <= '0;
            fire        <= '0;
            fire_x_pos  <= '0;
            busy        <= 1'b0;
            shots_fired <= '0;
`ifdef BOSS_AIM_EN
            dir_r       <= 2'b00;
            fire_dir_r  <= 2'b00;
`endif
        end else begin
            frame_q  <= frame_clk;
            fire     <= '0;
            reserved <= reserved_kept;
            if (!enable) begin
                state     <= S_IDLE;
                cnt       <= '0;
                burst_cnt <= '0;
                reserved  <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_COOLDOWN;
                        cnt   <= CNT_W'(COOLDOWN_FRAMES);
                        busy  <= 1'b1;
                    end
                    S_COOLDOWN: begin
                        if (tick) begin
                            if (cnt <= CNT_W'(1)) begin
`ifdef BOSS_AIM_EN
                                state     <= S_AIM;
`else
                                state     <= S_BURST;
                                burst_cnt <= '0;
`endif
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end
                    end
`ifdef BOSS_AIM_EN
                    S_AIM: begin
                        dir_r     <= aim_dir;
                        burst_cnt <= '0;
                        state     <= S_BURST;
                    end
`endif
                    S_BURST: begin
                        // with no free slot the burst simply waits here
                        if (free != '0) begin
                            fire       <= pick;
                            fire_x_pos <= boss_x_pos;
`ifdef BOSS_AIM_EN
                            fire_dir_r <= dir_r;
`endif
                            if (shots_fired != 16'hFFFF) begin
                                shots_fired <= shots_fired + 16'd1;
                            end
                            burst_cnt <= burst_next[BC_W-1:0];
                            reserved  <= reserved_kept | pick;
                            if (burst_last) begin
                                state <= S_COOLDOWN;
                                cnt   <= CNT_W'(COOLDOWN_FRAMES);
                            end else begin
                                state <= S_GAP;
                                cnt   <= CNT_W'(BURST_GAP_FRAMES);
                            end
                        end
                    end
                    S_GAP: begin
                        if (tick) begin
                            if (cnt <= CNT_W'(1)) begin
                                state <= S_BURST;
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boss_missile_scheduler.sv
// Directed bench for boss_missile_scheduler: vector table of aim cases plus hand-written burst,
// stall, enable-drop, saturation and reset sequences.
module tb_boss_missile_scheduler;

    localparam int NS = 3;
`ifdef BOSS_AIM_EN
    localparam bit AIM = 1'b1;
    localparam int LAT = 2;
`else
    localparam bit AIM = 1'b0;
    localparam int LAT = 1;
`endif

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          frame_clk = 1'b0;
    logic          enable = 1'b0;
    logic [9:0]    boss_x_pos = '0;
    logic [9:0]    player_x_pos = '0;
    logic [NS-1:0] slot_active = '0;
    logic [NS-1:0] fire;
    logic [9:0]    fire_x_pos;
    logic [1:0]    fire_dir;
    logic          busy;
    logic [15:0]   shots_fired;

    boss_missile_scheduler #(
        .NUM_SLOTS(NS),
        .COOLDOWN_FRAMES(2),
        .BURST_LEN(3),
        .BURST_GAP_FRAMES(1),
        .AIM_DEADZONE(16)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_clk(frame_clk),
        .enable(enable),
        .boss_x_pos(boss_x_pos),
        .player_x_pos(player_x_pos),
        .slot_active(slot_active),
        .fire(fire),
        .fire_x_pos(fire_x_pos),
        .fire_dir(fire_dir),
        .busy(busy),
        .shots_fired(shots_fired)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int nfires = 0;
    int exp_shots = 0;
    bit echo = 1'b0;

    typedef struct {
        logic [9:0] boss;
        logic [9:0] player;
        logic [1:0] dir;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one clock; optional downstream model marks fired slots in flight one Clk later
    task automatic cyc();
        @(negedge Clk);
        if (fire != '0) nfires++;
        if (echo) slot_active = slot_active | fire;
    endtask

    task automatic toggle(input int n, output int nf);
        int n0;
        n0 = nfires;
        for (int c = 0; c < n; c++) begin
            frame_clk = ~frame_clk;
            cyc();
        end
        frame_clk = 1'b0;
        nf = nfires - n0;
    endtask

    task automatic run_until_fire(input int maxc, output logic [NS-1:0] f, output bit ok);
        ok = 1'b0;
        f  = '0;
        for (int c = 0; c < maxc; c++) begin
            frame_clk = ~frame_clk;
            cyc();
            if (fire != '0) begin
                f  = fire;
                ok = 1'b1;
                break;
            end
        end
        frame_clk = 1'b0;
    endtask

    // enable from IDLE, two frame ticks of cooldown, then the first shot LAT clocks after tick 2
    task automatic first_shot(input logic [9:0] bx, input logic [9:0] px, input logic [1:0] dir,
                              input string tag);
        int n0;
        boss_x_pos   = bx;
        player_x_pos = px;
        frame_clk    = 1'b0;
        enable       = 1'b1;
        n0           = nfires;
        cyc();
        chk($sformatf("%s busy", tag), busy, 1);
        frame_clk = 1'b1; cyc();
        frame_clk = 1'b0; cyc();
        frame_clk = 1'b1; cyc();
        frame_clk = 1'b0;
        chk($sformatf("%s no early fire", tag), nfires - n0, 0);
        for (int k = 1; k <= LAT; k++) begin
            cyc();
            chk($sformatf("%s fire lat%0d", tag, k), fire, (k == LAT) ? 3'b001 : 3'b000);
        end
        exp_shots++;
        chk($sformatf("%s fire_x", tag), fire_x_pos, bx);
        chk($sformatf("%s fire_dir", tag), fire_dir, dir);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NS-1:0] f;
        bit            ok;
        int            nf;

        tbl[0]  = '{10'd300,  10'd300,  2'b00};
        tbl[1]  = '{10'd300,  10'd100,  2'b01};
        tbl[2]  = '{10'd300,  10'd500,  2'b10};
        tbl[3]  = '{10'd300,  10'd316,  2'b00};
        tbl[4]  = '{10'd300,  10'd284,  2'b00};
        tbl[5]  = '{10'd300,  10'd283,  2'b01};
        tbl[6]  = '{10'd300,  10'd317,  2'b10};
        tbl[7]  = '{10'd10,   10'd0,    2'b00};
        tbl[8]  = '{10'd1020, 10'd1023, 2'b00};
        tbl[9]  = '{10'd5,    10'd1023, 2'b10};
        tbl[10] = '{10'd1023, 10'd0,    2'b01};

        Reset = 1'b1;
        cyc(); cyc();
        chk("reset fire", fire, 0);
        chk("reset fire_x", fire_x_pos, 0);
        chk("reset fire_dir", fire_dir, 0);
        chk("reset busy", busy, 0);
        chk("reset shots", shots_fired, 0);
        Reset = 1'b0;
        cyc();

        for (int i = 0; i < 11; i++) begin
            enable      = 1'b0;
            echo        = 1'b0;
            slot_active = '0;
            cyc(); cyc();
            first_shot(tbl[i].boss, tbl[i].player, AIM ? tbl[i].dir : 2'b00, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d shots", i), shots_fired, exp_shots);
        end

        // full burst with slots reported in flight one Clk after each launch
        enable = 1'b0;
        cyc(); cyc();
        slot_active = '0;
        echo        = 1'b1;
        first_shot(10'd300, 10'd300, 2'b00, "burst0");
        run_until_fire(20, f, ok);
        chk("burst1 seen", ok, 1);
        chk("burst1 slot", f, 3'b010);
        exp_shots++;
        run_until_fire(20, f, ok);
        chk("burst2 seen", ok, 1);
        chk("burst2 slot", f, 3'b100);
        exp_shots++;
        chk("burst shots", shots_fired, exp_shots);
        chk("burst busy", busy, 1);

        // every slot busy: next burst stalls without firing
        toggle(12, nf);
        chk("stall no fire", nf, 0);
        chk("stall busy", busy, 1);
        slot_active[1] = 1'b0;
        ok = 1'b0;
        f  = '0;
        for (int c = 0; c < 2; c++) begin
            cyc();
            if (fire != '0) begin
                f  = fire;
                ok = 1'b1;
                break;
            end
        end
        chk("unstall seen", ok, 1);
        chk("unstall slot", f, 3'b010);
        exp_shots++;

        // now in GAP: dropping enable returns to IDLE at once
        enable = 1'b0;
        cyc();
        chk("disable busy", busy, 0);
        chk("disable fire", fire, 0);
        toggle(6, nf);
        chk("disabled no fire", nf, 0);
        chk("disabled busy", busy, 0);
        chk("disabled shots", shots_fired, exp_shots);
        echo        = 1'b0;
        slot_active = '0;
        first_shot(10'd300, 10'd300, 2'b00, "reen");

        // shot counter saturation
        force dut.shots_fired = 16'hFFFE;
        cyc();
        release dut.shots_fired;
        cyc();
        run_until_fire(20, f, ok);
        chk("sat1 seen", ok, 1);
        chk("sat1 shots", shots_fired, 16'hFFFF);
        run_until_fire(20, f, ok);
        chk("sat2 seen", ok, 1);
        chk("sat2 shots", shots_fired, 16'hFFFF);
        run_until_fire(40, f, ok);
        chk("sat3 seen", ok, 1);
        chk("sat3 shots", shots_fired, 16'hFFFF);

        // reset while BURST is waiting on slots; freeing them in the same cycle must not launch
        enable = 1'b0;
        cyc(); cyc();
        slot_active  = '1;
        player_x_pos = 10'd100;
        enable       = 1'b1;
        toggle(12, nf);
        chk("prereset no fire", nf, 0);
        chk("prereset busy", busy, 1);
        slot_active = '0;
        Reset       = 1'b1;
        cyc();
        chk("midreset fire", fire, 0);
        chk("midreset fire_x", fire_x_pos, 0);
        chk("midreset fire_dir", fire_dir, 0);
        chk("midreset busy", busy, 0);
        chk("midreset shots", shots_fired, 0);
        Reset  = 1'b0;
        enable = 1'b0;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
